// File: rtl/order_gate.sv
`default_nettype none
// ============================================================================
// Module   : order_gate
// Brief    : Order gate downstream of the price risk firewall. Forwards orders
//            over valid/ready only while safe_to_trade is high. Enforces a
//            per-order quantity cap and a token-bucket rate limit. Latches a
//            kill state after a sustained firewall lock. Every dropped order
//            is reported with a reject code and a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module order_gate #(
  parameter int MAX_TOKENS    = 8,
  parameter int REFILL_CYCLES = 16,
  parameter int KILL_CYCLES   = 4,
  parameter int MAX_QTY       = 1000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             safe_to_trade,
  input  logic             kill_clear,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic [31:0]      ord_price,
  input  logic [15:0]      ord_qty,
  input  logic             ord_side,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_price,
  output logic [15:0]      out_qty,
  output logic             out_side,
  output logic [1:0]       state,
  output logic             reject_pulse,
  output logic [1:0]       reject_code,
  output logic [CNT_W-1:0] reject_count
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int TOK_W = $clog2(MAX_TOKENS + 1);
  localparam int REF_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam int LOW_W = $clog2(KILL_CYCLES + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [TOK_W-1:0] C_TOK_MAX   = TOK_W'(MAX_TOKENS);
  localparam logic [REF_W-1:0] C_REF_LAST  = REF_W'(REFILL_CYCLES - 1);
  localparam logic [LOW_W-1:0] C_KILL_LIM  = LOW_W'(KILL_CYCLES);
  localparam logic [LOW_W-1:0] C_KILL_PRE  = LOW_W'(KILL_CYCLES - 1);
  localparam logic [15:0]      C_MAX_QTY   = 16'(MAX_QTY);

  localparam logic [1:0] C_REJ_NONE  = 2'd0;
  localparam logic [1:0] C_REJ_HALT  = 2'd1;
  localparam logic [1:0] C_REJ_THROT = 2'd2;
  localparam logic [1:0] C_REJ_QTY   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_KILLED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [LOW_W-1:0]  low_q, low_d;
  logic [TOK_W-1:0]  tok_q, tok_d;
  logic [REF_W-1:0]  ref_q, ref_d;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_price_q, out_price_d;
  logic [15:0]       out_qty_q,   out_qty_d;
  logic              out_side_q,  out_side_d;

  logic              rej_pulse_q, rej_pulse_d;
  logic [1:0]        rej_code_q,  rej_code_d;
  logic [CNT_W-1:0]  rej_cnt_q,   rej_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              w_low_hit;
  logic              w_enter_kill;
  logic              w_accept;
  logic              w_qty_bad;
  logic              w_rej_state;
  logic              w_rej_qty;
  logic              w_rej_tok;
  logic              w_rej_ord;
  logic              w_fwd;
  logic              w_flush;
  logic              w_refill;
  logic [1:0]        w_rej_n;
  logic [SUM_W-1:0]  w_cnt_sum;

  // This low sample completes the run of KILL_CYCLES consecutive lows.
  assign w_low_hit    = !safe_to_trade && (low_q >= C_KILL_PRE);
  assign w_enter_kill = (state_d == ST_KILLED) && (state_q != ST_KILLED);

  // Outside RUN the gate always accepts, so upstream drains into rejects.
  assign ord_ready = (state_q == ST_RUN) ? (!out_valid_q || out_ready) : 1'b1;
  assign w_accept  = ord_valid && ord_ready;

  assign w_qty_bad   = (ord_qty == 16'd0) || (ord_qty > C_MAX_QTY);
  assign w_rej_state = w_accept && (state_q != ST_RUN);
  assign w_rej_qty   = w_accept && (state_q == ST_RUN) && w_qty_bad;
  assign w_rej_tok   = w_accept && (state_q == ST_RUN) && !w_qty_bad
                       && (tok_q == '0);
  assign w_fwd       = w_accept && (state_q == ST_RUN) && !w_qty_bad
                       && (tok_q != '0);
  assign w_rej_ord   = w_rej_state || w_rej_qty || w_rej_tok;

  // A pending entry that is not being taken this edge dies with the kill.
  assign w_flush = w_enter_kill && out_valid_q && !out_ready;

  // An order reject and a kill flush on the same edge both count.
  assign w_rej_n   = {1'b0, w_rej_ord} + {1'b0, w_flush};
  assign w_cnt_sum = {1'b0, rej_cnt_q} + SUM_W'(w_rej_n);

  assign w_refill = (ref_q == C_REF_LAST);

  // Firewall run-length counter and RUN/HALT/KILLED next-state logic
  always_comb begin
    state_d = state_q;
    low_d   = low_q;

    if (safe_to_trade) begin
      low_d = '0;
    end else if (low_q != C_KILL_LIM) begin
      low_d = low_q + LOW_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (!safe_to_trade) begin
          state_d = w_low_hit ? ST_KILLED : ST_HALT;
        end
      end
      ST_HALT: begin
        if (safe_to_trade) begin
          state_d = ST_RUN;
        end else if (w_low_hit) begin
          state_d = ST_KILLED;
        end
      end
      ST_KILLED: begin
        // Re-arm only with the firewall approving on the same edge.
        if (kill_clear && safe_to_trade) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Token bucket: free-running refill timer, consume on forward
  always_comb begin
    ref_d = w_refill ? '0 : ref_q + REF_W'(1);
    tok_d = tok_q;
    if (w_refill && !w_fwd) begin
      if (tok_q != C_TOK_MAX) begin
        tok_d = tok_q + TOK_W'(1);
      end
    end else if (!w_refill && w_fwd) begin
      tok_d = tok_q - TOK_W'(1);
    end
  end

  // Output register: load on forward, hold while stalled, flush on kill
  always_comb begin
    out_valid_d = out_valid_q;
    out_price_d = out_price_q;
    out_qty_d   = out_qty_q;
    out_side_d  = out_side_q;

    if (w_fwd) begin
      out_valid_d = 1'b1;
      out_price_d = ord_price;
      out_qty_d   = ord_qty;
      out_side_d  = ord_side;
    end else if (w_flush) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reject strobe, code and saturating counter
  always_comb begin
    rej_pulse_d = w_rej_ord || w_flush;
    rej_code_d  = C_REJ_NONE;
    if (w_flush || w_rej_state) begin
      rej_code_d = C_REJ_HALT;
    end else if (w_rej_qty) begin
      rej_code_d = C_REJ_QTY;
    end else if (w_rej_tok) begin
      rej_code_d = C_REJ_THROT;
    end

    if (w_cnt_sum[CNT_W]) begin
      rej_cnt_d = '1;
    end else begin
      rej_cnt_d = w_cnt_sum[CNT_W-1:0];
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      low_q       <= '0;
      tok_q       <= C_TOK_MAX;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      out_price_q <= '0;
      out_qty_q   <= '0;
      out_side_q  <= 1'b0;
      rej_pulse_q <= 1'b0;
      rej_code_q  <= C_REJ_NONE;
      rej_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      low_q       <= low_d;
      tok_q       <= tok_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      out_price_q <= out_price_d;
      out_qty_q   <= out_qty_d;
      out_side_q  <= out_side_d;
      rej_pulse_q <= rej_pulse_d;
      rej_code_q  <= rej_code_d;
      rej_cnt_q   <= rej_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_price    = out_price_q;
  assign out_qty      = out_qty_q;
  assign out_side     = out_side_q;
  assign state        = state_q;
  assign reject_pulse = rej_pulse_q;
  assign reject_code  = rej_code_q;
  assign reject_count = rej_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_order_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_gate
// Brief    : Self-checking bench for order_gate: a table of directed vectors
//            for burst, throttle, quantity and refill behaviour, followed by
//            hand-written sequences for saturation, HALT, kill latch and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        safe_to_trade;
  logic        kill_clear;
  logic        ord_valid;
  logic        ord_ready;
  logic [31:0] ord_price;
  logic [15:0] ord_qty;
  logic        ord_side;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_price;
  logic [15:0] out_qty;
  logic        out_side;
  logic [1:0]  state;
  logic        reject_pulse;
  logic [1:0]  reject_code;
  logic [15:0] reject_count;

  int tests   = 0;
  int fails   = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  order_gate #(
    .MAX_TOKENS   (8),
    .REFILL_CYCLES(16),
    .KILL_CYCLES  (4),
    .MAX_QTY      (1000),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .safe_to_trade(safe_to_trade),
    .kill_clear   (kill_clear),
    .ord_valid    (ord_valid),
    .ord_ready    (ord_ready),
    .ord_price    (ord_price),
    .ord_qty      (ord_qty),
    .ord_side     (ord_side),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_price    (out_price),
    .out_qty      (out_qty),
    .out_side     (out_side),
    .state        (state),
    .reject_pulse (reject_pulse),
    .reject_code  (reject_code),
    .reject_count (reject_count)
  );

  typedef struct {
    logic        safe;
    logic        kc;
    logic        ov;
    logic        ordy;
    logic [15:0] qty;
    logic [31:0] price;
    logic        side;
    logic        e_ovalid;
    logic [31:0] e_price;
    logic [15:0] e_qty;
    logic        e_side;
    logic        e_pulse;
    logic [1:0]  e_code;
    logic [1:0]  e_state;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    input logic ov, input logic [15:0] qty, input logic [31:0] price,
    input logic side, input logic e_ovalid, input logic e_pulse,
    input logic [1:0] e_code, input logic [15:0] e_cnt);
    vec_t v;
    v.safe     = 1'b1;
    v.kc       = 1'b0;
    v.ov       = ov;
    v.ordy     = 1'b1;
    v.qty      = qty;
    v.price    = price;
    v.side     = side;
    v.e_ovalid = e_ovalid;
    v.e_price  = price;
    v.e_qty    = qty;
    v.e_side   = side;
    v.e_pulse  = e_pulse;
    v.e_code   = e_code;
    v.e_state  = 2'd0;
    v.e_cnt    = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic drive(input logic safe, input logic kc, input logic ov,
                       input logic [15:0] qty, input logic [31:0] price,
                       input logic side, input logic ordy);
    safe_to_trade = safe;
    kill_clear    = kc;
    ord_valid     = ov;
    ord_qty       = qty;
    ord_price     = price;
    ord_side      = side;
    out_ready     = ordy;
  endtask

  // Reset pulse placed between clock edges
  task automatic do_reset;
    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, " out_valid"},    32'(out_valid),    32'd0);
    chk({tag, " out_price"},    out_price,         32'd0);
    chk({tag, " out_qty"},      32'(out_qty),      32'd0);
    chk({tag, " out_side"},     32'(out_side),     32'd0);
    chk({tag, " state"},        32'(state),        32'd0);
    chk({tag, " reject_pulse"}, 32'(reject_pulse), 32'd0);
    chk({tag, " reject_code"},  32'(reject_code),  32'd0);
    chk({tag, " reject_count"}, 32'(reject_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fwd;
    logic seen_rej;

    // Burst of 10 from reset: 8 forward, 2 throttled
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, 16'd100, 32'd1000 + 32'(i), 1'(i), 1'b1, 1'b0, 2'd0, 16'd0);
    tbl[8]  = mk(1'b1, 16'd100,  32'd1008, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1);
    tbl[9]  = mk(1'b1, 16'd100,  32'd1009, 1'b1, 1'b0, 1'b1, 2'd2, 16'd2);
    // Quantity limits take priority over the empty bucket
    tbl[10] = mk(1'b1, 16'd0,    32'd1,    1'b0, 1'b0, 1'b1, 2'd3, 16'd3);
    tbl[11] = mk(1'b1, 16'd1001, 32'd2,    1'b0, 1'b0, 1'b1, 2'd3, 16'd4);
    // Idle until the refill at edge 16
    for (int i = 12; i < 16; i++)
      tbl[i] = mk(1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd4);
    // One refilled token: qty 1000 forwards, the next order throttles
    tbl[16] = mk(1'b1, 16'd1000, 32'd5000, 1'b1, 1'b1, 1'b0, 2'd0, 16'd4);
    tbl[17] = mk(1'b1, 16'd1000, 32'd5001, 1'b0, 1'b0, 1'b1, 2'd2, 16'd5);

    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    edge_no = 0;
    chk_all_reset("reset");

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].safe, tbl[i].kc, tbl[i].ov, tbl[i].qty, tbl[i].price,
            tbl[i].side, tbl[i].ordy);
      tick();
      chk($sformatf("tbl[%0d] out_valid", i),    32'(out_valid),    32'(tbl[i].e_ovalid));
      chk($sformatf("tbl[%0d] reject_pulse", i), 32'(reject_pulse), 32'(tbl[i].e_pulse));
      chk($sformatf("tbl[%0d] reject_code", i),  32'(reject_code),  32'(tbl[i].e_code));
      chk($sformatf("tbl[%0d] reject_count", i), 32'(reject_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl[%0d] state", i),        32'(state),        32'(tbl[i].e_state));
      if (tbl[i].e_ovalid) begin
        chk($sformatf("tbl[%0d] out_price", i), out_price,      tbl[i].e_price);
        chk($sformatf("tbl[%0d] out_qty", i),   32'(out_qty),   32'(tbl[i].e_qty));
        chk($sformatf("tbl[%0d] out_side", i),  32'(out_side),  32'(tbl[i].e_side));
      end
    end

    // Long idle: bucket saturates at 8, then a 9-order burst right after a
    // refill edge (no refill can land inside the burst)
    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 240; k++) begin
      tick();
      if (edge_no >= 218 && (edge_no % 16) == 0) break;
    end
    fwd = 0;
    seen_rej = 1'b0;
    for (int j = 0; j < 9; j++) begin
      drive(1'b1, 1'b0, 1'b1, 16'd10, 32'd7000 + 32'(j), 1'b0, 1'b1);
      tick();
      if (out_valid && out_price == 32'd7000 + 32'(j) && out_qty == 16'd10) fwd++;
      if (j == 8) seen_rej = reject_pulse && (reject_code == 2'd2);
    end
    chk("saturated burst forwards", 32'(fwd), 32'd8);
    chk("saturated burst 9th throttled", 32'(seen_rej), 32'd1);

    // HALT with a stalled pending entry
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 16'd5, 32'h11, 1'b0, 1'b0);
    tick();                                                       // e1
    chk("halt pend out_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("run stalled ord_ready", 32'(ord_ready), 32'd0);
    safe_to_trade = 1'b0;
    tick();                                                       // e2
    chk("halt state", 32'(state), 32'd1);
    chk("halt pend kept", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'd7, 32'h33, 1'b1, 1'b0);
    #1;
    chk("halt ord_ready", 32'(ord_ready), 32'd1);
    tick();                                                       // e3
    chk("halt reject_pulse", 32'(reject_pulse), 32'd1);
    chk("halt reject_code", 32'(reject_code), 32'd1);
    chk("halt reject_count", 32'(reject_count), 32'd1);
    chk("halt out_price held", out_price, 32'h11);
    chk("halt out_qty held", 32'(out_qty), 32'd5);
    chk("halt out_valid held", 32'(out_valid), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0);
    tick();                                                       // e4
    chk("halt->run state", 32'(state), 32'd0);
    chk("halt->run pend", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();                                                       // e5
    chk("pend drained", 32'(out_valid), 32'd0);

    // Kill latch with a pending entry
    drive(1'b1, 1'b0, 1'b1, 16'd9, 32'h22, 1'b0, 1'b0);
    tick();                                                       // e6
    chk("kill pend load", out_price, 32'h22);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0);
    tick();                                                       // e7
    chk("kill low1 state", 32'(state), 32'd1);
    kill_clear = 1'b1;
    tick();                                                       // e8
    chk("kill low2 state", 32'(state), 32'd1);
    kill_clear = 1'b0;
    tick();                                                       // e9
    chk("kill low3 state", 32'(state), 32'd1);
    chk("kill low3 pend", 32'(out_valid), 32'd1);
    tick();                                                       // e10
    chk("killed state", 32'(state), 32'd2);
    chk("kill flush out_valid", 32'(out_valid), 32'd0);
    chk("kill flush pulse", 32'(reject_pulse), 32'd1);
    chk("kill flush code", 32'(reject_code), 32'd1);
    chk("kill flush count", 32'(reject_count), 32'd2);
    kill_clear = 1'b1;
    tick();                                                       // e11
    chk("kill_clear ignored unsafe", 32'(state), 32'd2);
    chk("killed no pulse", 32'(reject_pulse), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 16'd9, 32'h44, 1'b0, 1'b1);
    tick();                                                       // e12
    chk("killed safe no clear", 32'(state), 32'd2);
    chk("killed order code", 32'(reject_code), 32'd1);
    chk("killed order count", 32'(reject_count), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b1);
    tick();                                                       // e13
    chk("rearm state", 32'(state), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 16'd9, 32'h55, 1'b1, 1'b0);
    tick();                                                       // e14
    chk("rearm forward price", out_price, 32'h55);
    chk("rearm forward side", 32'(out_side), 32'd1);

    // Asynchronous reset between edges
    drive(1'b1, 1'b0, 1'b1, 16'd9, 32'h66, 1'b0, 1'b1);
    tick();                                                       // e15
    chk("pre-reset out_price", out_price, 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_reset("async reset");
    ord_valid = 1'b0;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
